io_timer_irq: RTL and testbench

Memory-mapped timer and interrupt source on the cpu65CE02 data bus. It decodes an 8-byte register window from the CPU's next-cycle address, behaves like the synchronous memory on reads and writes, and drives the CPU `irq` and `nmi` inputs. It combines a software-driven port, whose bit 0 and bit 1 force irq and nmi directly, with a 16-bit prescaled down-counter that raises an interrupt on expiry. The system bus mux selects `data_o` when `sel` is high and otherwise selects memory.

---
 rtl/io_timer_pkg.sv | 21 ++
 rtl/io_timer_irq_if.sv | 11 +
 rtl/io_prescaler.sv | 21 ++
 rtl/io_timer_irq.sv | 124 ++++++++++++
 tb/tb_io_timer_irq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register map, control/status bit positions and window decode for io_timer_irq
package io_timer_pkg;
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hbff8;
  localparam logic [2:0] OFF_PORT      = 3'd0;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd1;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd2;
  localparam logic [2:0] OFF_CTRL      = 3'd3;
  localparam logic [2:0] OFF_STATUS    = 3'd4;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd5;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd6;
  localparam logic [2:0] OFF_PRESCALE  = 3'd7;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IE     = 2;
  localparam int CTRL_NMISEL = 3;
  localparam int STATUS_EXP  = 0;
  localparam int STATUS_IRQ  = 7;
  function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
    return ((addr ^ base) & 16'hfff8) == 16'h0000;
  endfunction
endpackage

// File: rtl/io_timer_irq_if.sv
// io_timer_irq_if: CPU next-cycle bus view of the timer register window
interface io_timer_irq_if;
  logic [15:0] address_next;
  logic        write_next;
  logic        ready;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        sel;
  modport master (output address_next, write_next, ready, data_i, input data_o, sel);
  modport slave (input address_next, write_next, ready, data_i, output data_o, sel);
endinterface

// File: rtl/io_prescaler.sv
// io_prescaler: 8-bit wrap counter producing one tick every divisor+1 enabled clocks
module io_prescaler (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] divisor,
  output logic       tick
);
  logic [7:0] cnt_q, cnt_d;
  assign tick = enable && cnt_q == divisor;
  // advance while enabled, restart on tick or clear
  always_comb begin
    cnt_d = clear ? 8'h00 : tick ? 8'h00 : enable ? cnt_q + 8'd1 : cnt_q;
  end
  // prescale count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 8'h00;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/io_timer_irq.sv
// io_timer_irq: bus-mapped software port plus prescaled 16-bit down-counter driving irq/nmi
module io_timer_irq
  import io_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic           clk,
  input  logic           reset_n,
  io_timer_irq_if.slave  bus,
  output logic [7:0]     port_out,
  output logic           irq,
  output logic           nmi
);
  logic        hit, wr, rd;
  logic [2:0]  off;
  logic        wr_port, wr_lo, wr_hi, wr_ctrl, wr_status, wr_pre, rd_lo;
  logic        tick, tick_en, expire;
  logic [7:0]  port_q, port_d, rld_lo_q, rld_lo_d, rld_hi_q, rld_hi_d;
  logic [7:0]  pre_q, pre_d, snap_q, snap_d, data_q, data_d, rdata;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [15:0] cnt_q, cnt_d;
  logic        exp_q, exp_d, sel_q, sel_d, irq_q, irq_d, nmi_q, nmi_d;

  assign hit       = in_window(bus.address_next, BASE_ADDR);
  assign off       = bus.address_next[2:0];
  assign wr        = hit && bus.write_next && bus.ready;
  assign rd        = hit && !bus.write_next && bus.ready;
  assign wr_port   = wr && off == OFF_PORT;
  assign wr_lo     = wr && off == OFF_RELOAD_LO;
  assign wr_hi     = wr && off == OFF_RELOAD_HI;
  assign wr_ctrl   = wr && off == OFF_CTRL;
  assign wr_status = wr && off == OFF_STATUS;
  assign wr_pre    = wr && off == OFF_PRESCALE;
  assign rd_lo     = rd && off == OFF_COUNT_LO;

  io_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (ctrl_q[CTRL_EN]),
    .clear   (wr_hi),
    .divisor (pre_q),
    .tick    (tick)
  );

  // a CTRL write that drops EN swallows a coincident tick
  assign tick_en = tick && ctrl_q[CTRL_EN] && !(wr_ctrl && !bus.data_i[CTRL_EN]);
  assign expire  = tick_en && cnt_q == 16'h0000;

  // read data mux over the register window
  always_comb begin
    rdata = 8'h00;
    case (off)
      OFF_PORT:      rdata = port_q;
      OFF_RELOAD_LO: rdata = rld_lo_q;
      OFF_RELOAD_HI: rdata = rld_hi_q;
      OFF_CTRL:      rdata = {4'h0, ctrl_q};
      OFF_STATUS: begin
        rdata[STATUS_EXP] = exp_q;
        rdata[STATUS_IRQ] = irq_q | nmi_q;
      end
      OFF_COUNT_LO:  rdata = cnt_q[7:0];
      OFF_COUNT_HI:  rdata = snap_q;
      OFF_PRESCALE:  rdata = pre_q;
      default:       rdata = 8'h00;
    endcase
  end

  // next state: register writes, counter/expiry, bus read capture, interrupt pins
  always_comb begin
    port_d   = wr_port ? bus.data_i : port_q;
    rld_lo_d = wr_lo ? bus.data_i : rld_lo_q;
    rld_hi_d = wr_hi ? bus.data_i : rld_hi_q;
    pre_d    = wr_pre ? bus.data_i : pre_q;
    ctrl_d   = wr_ctrl ? bus.data_i[3:0] : ctrl_q;
    if (expire && !ctrl_q[CTRL_AUTO]) ctrl_d[CTRL_EN] = 1'b0;
    if (wr_hi) ctrl_d[CTRL_EN] = 1'b1;
    cnt_d    = wr_hi ? {bus.data_i, rld_lo_q}
             : expire ? (ctrl_q[CTRL_AUTO] ? {rld_hi_q, rld_lo_q} : 16'h0000)
             : tick_en ? cnt_q - 16'd1 : cnt_q;
    exp_d    = expire || (exp_q && !(wr_status && bus.data_i[STATUS_EXP]));
    snap_d   = rd_lo ? cnt_q[15:8] : snap_q;
    data_d   = rd ? rdata : data_q;
    sel_d    = bus.ready ? hit : sel_q;
    irq_d    = port_q[0] | (exp_q & ctrl_q[CTRL_IE] & ~ctrl_q[CTRL_NMISEL]);
    nmi_d    = port_q[1] | (exp_q & ctrl_q[CTRL_IE] & ctrl_q[CTRL_NMISEL]);
  end

  // state registers, all cleared by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_q   <= 8'h00;
      rld_lo_q <= 8'h00;
      rld_hi_q <= 8'h00;
      pre_q    <= 8'h00;
      ctrl_q   <= 4'h0;
      cnt_q    <= 16'h0000;
      exp_q    <= 1'b0;
      snap_q   <= 8'h00;
      data_q   <= 8'h00;
      sel_q    <= 1'b0;
      irq_q    <= 1'b0;
      nmi_q    <= 1'b0;
    end else begin
      port_q   <= port_d;
      rld_lo_q <= rld_lo_d;
      rld_hi_q <= rld_hi_d;
      pre_q    <= pre_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      snap_q   <= snap_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
      irq_q    <= irq_d;
      nmi_q    <= nmi_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.sel    = sel_q;
  assign port_out   = port_q;
  assign irq        = irq_q;
  assign nmi        = nmi_q;
endmodule

// File: tb/tb_io_timer_irq.sv
// tb_io_timer_irq: directed bus traffic with a read scoreboard checked by an independent monitor
module tb_io_timer_irq;
  localparam logic [15:0] BASE = 16'hbff8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] port_out;
  logic       irq, nmi;

  io_timer_irq_if bus();

  io_timer_irq #(.BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .port_out (port_out),
    .irq      (irq),
    .nmi      (nmi)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic       i;
    logic       n;
    logic [7:0] p;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic rd_seen = 1'b0;
  logic idle_seen = 1'b0;
  logic done = 1'b0;

  // bus observer: classify each committed edge
  always @(posedge clk) begin
    rd_seen   <= reset_n && bus.ready && !bus.write_next && (bus.address_next >> 3) == (BASE >> 3);
    idle_seen <= reset_n && bus.ready && (bus.address_next >> 3) != (BASE >> 3);
  end

  // monitor: compare outputs half a clock after each edge
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) begin
      n_chk++;
      if ({bus.data_o, bus.sel, port_out, irq, nmi} !== 19'h0) begin
        n_fail++;
        $display("FAIL reset_outputs: got data=%h sel=%b port=%h irq=%b nmi=%b, want all zero",
                 bus.data_o, bus.sel, port_out, irq, nmi);
      end
    end else if (rd_seen) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: got data=%h with no expected entry, want none", bus.data_o);
      end else begin
        e = q.pop_front();
        if ({bus.data_o, bus.sel, irq, nmi, port_out} !== {e.d, 1'b1, e.i, e.n, e.p}) begin
          n_fail++;
          $display("FAIL %s: got data=%h sel=%b irq=%b nmi=%b port=%h, want data=%h sel=1 irq=%b nmi=%b port=%h",
                   e.name, bus.data_o, bus.sel, irq, nmi, port_out, e.d, e.i, e.n, e.p);
        end
      end
    end else if (idle_seen) begin
      n_chk++;
      if (bus.sel !== 1'b0) begin
        n_fail++;
        $display("FAIL sel_miss: got sel=%b, want 0", bus.sel);
      end
    end
    if (done) begin
      n_chk++;
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL scoreboard_drain: got %0d pending reads, want 0", q.size());
      end
    end
  end

  task automatic cyc(input logic [15:0] a, input logic w, input logic [7:0] d, input logic r = 1'b1);
    bus.address_next = a;
    bus.write_next   = w;
    bus.data_i       = d;
    bus.ready        = r;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    cyc(BASE + 16'(o), 1'b1, d);
  endtask

  task automatic rd(input string nm, input logic [2:0] o, input logic [7:0] d,
                    input logic i, input logic n, input logic [7:0] p);
    exp_t e;
    e.name = nm;
    e.d = d;
    e.i = i;
    e.n = n;
    e.p = p;
    q.push_back(e);
    cyc(BASE + 16'(o), 1'b0, 8'h00);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(16'h0000, 1'b0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.address_next = 16'h0000;
    bus.write_next   = 1'b0;
    bus.data_i       = 8'h00;
    bus.ready        = 1'b1;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    rd("reset_ctrl", 3'd3, 8'h00, 0, 0, 8'h00);
    // software port forcing
    wr(3'd0, 8'h01);
    rd("irq_pre_status", 3'd4, 8'h00, 1, 0, 8'h01);
    rd("irq_status", 3'd4, 8'h80, 1, 0, 8'h01);
    rd("port_rb", 3'd0, 8'h01, 1, 0, 8'h01);
    wr(3'd0, 8'h02);
    rd("port_nmi", 3'd0, 8'h02, 0, 1, 8'h02);
    wr(3'd0, 8'h00);
    rd("port_clear", 3'd0, 8'h00, 0, 0, 8'h00);
    // one-shot: prescale 3, reload 5 -> expiry 24 clocks after the HI write
    wr(3'd7, 8'h03);
    wr(3'd3, 8'h04);
    wr(3'd1, 8'h05);
    wr(3'd2, 8'h00);
    rd("os_ctrl_en", 3'd3, 8'h05, 0, 0, 8'h00);
    idle(22);
    rd("os_t24", 3'd4, 8'h00, 0, 0, 8'h00);
    rd("os_t25", 3'd4, 8'h01, 1, 0, 8'h00);
    rd("os_t26", 3'd4, 8'h81, 1, 0, 8'h00);
    rd("os_en_cleared", 3'd3, 8'h04, 1, 0, 8'h00);
    rd("os_count_zero", 3'd5, 8'h00, 1, 0, 8'h00);
    wr(3'd4, 8'h01);
    rd("os_clr_t1", 3'd4, 8'h80, 0, 0, 8'h00);
    rd("os_clr_t2", 3'd4, 8'h00, 0, 0, 8'h00);
    // auto-reload to nmi, reload 2, prescale 0; HI write coincides with an expiry
    wr(3'd7, 8'h00);
    wr(3'd1, 8'h02);
    wr(3'd3, 8'h0f);
    wr(3'd2, 8'h00);
    rd("ar_load_and_exp", 3'd4, 8'h01, 0, 1, 8'h00);
    rd("ar_count", 3'd5, 8'h01, 0, 1, 8'h00);
    wr(3'd4, 8'h01);
    rd("ar_set_wins", 3'd4, 8'h81, 0, 1, 8'h00);
    wr(3'd4, 8'h01);
    rd("ar_cleared", 3'd4, 8'h80, 0, 0, 8'h00);
    rd("ar_reexpire", 3'd4, 8'h01, 0, 1, 8'h00);
    rd("ar_hold", 3'd4, 8'h81, 0, 1, 8'h00);
    wr(3'd4, 8'h01);
    rd("ar_set_wins2", 3'd4, 8'h81, 0, 1, 8'h00);
    wr(3'd3, 8'h00);
    rd("dis_tick_ignored", 3'd5, 8'h01, 0, 0, 8'h00);
    wr(3'd4, 8'h01);
    rd("dis_status", 3'd4, 8'h00, 0, 0, 8'h00);
    // atomic 16-bit count read
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h01);
    rd("atom_lo", 3'd5, 8'h00, 0, 0, 8'h00);
    rd("atom_hi", 3'd6, 8'h01, 0, 0, 8'h00);
    rd("atom_lo2", 3'd5, 8'hfe, 0, 0, 8'h00);
    rd("atom_hi2", 3'd6, 8'h00, 0, 0, 8'h00);
    wr(3'd3, 8'h00);
    // ready gating, out-of-window decode, read-only offsets
    cyc(BASE, 1'b1, 8'haa, 1'b0);
    rd("rdy_low_write", 3'd0, 8'h00, 0, 0, 8'h00);
    cyc(BASE - 16'd1, 1'b1, 8'h55);
    cyc(BASE + 16'd8, 1'b1, 8'h77);
    cyc(BASE - 16'd1, 1'b0, 8'h00);
    rd("dec_port", 3'd0, 8'h00, 0, 0, 8'h00);
    rd("dec_prescale", 3'd7, 8'h00, 0, 0, 8'h00);
    wr(3'd5, 8'h33);
    wr(3'd6, 8'h44);
    rd("ro_count_hi", 3'd6, 8'h00, 0, 0, 8'h00);
    rd("ro_count_lo", 3'd5, 8'hfc, 0, 0, 8'h00);
    // asynchronous reset while interrupts are asserted
    wr(3'd1, 8'h12);
    wr(3'd0, 8'h03);
    idle(1);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    rd("rst_port", 3'd0, 8'h00, 0, 0, 8'h00);
    rd("rst_reload_lo", 3'd1, 8'h00, 0, 0, 8'h00);
    rd("rst_ctrl", 3'd3, 8'h00, 0, 0, 8'h00);
    idle(1);
    done = 1'b1;
    @(negedge clk);
    #1;
    done = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
